// File: rtl/groestl_subbytes_sched.sv
// Folded Groestl SubBytes sequencer: streams a 64-byte state through a shared
// bank of LANES S-boxes, LANES bytes per beat, and writes results back in place.
module groestl_subbytes_sched #(
    parameter int LANES    = 8,
    parameter int SBOX_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [511:0]         in_state,
    output logic [8*LANES-1:0]   sb_x,
    output logic                 sb_vld,
    input  logic [8*LANES-1:0]   sb_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [511:0]         out_state,
    output logic                 busy
);

    localparam int BEATS = 64 / LANES;
    localparam int CW    = $clog2(BEATS) + 1;
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BW    = 8 * LANES;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_fsm;
    state_t          w_fsm_nxt;
    logic [CW-1:0]   r_issue;
    logic [CW-1:0]   r_ret;
    logic [511:0]    r_state;
    logic            w_accept;
    logic            w_issue_live;
    logic            w_ret_vld;
    logic            w_ret_live;
    logic [BW-1:0]   w_beat [BEATS];

    assign w_accept     = (r_fsm == S_IDLE) && in_valid;
    assign w_issue_live = (r_fsm == S_RUN) && (r_issue < CW'(BEATS));
    assign w_ret_live   = (r_fsm == S_RUN) && w_ret_vld;

    // Beat view of the state register, one slice per issue slot
    for (genvar g = 0; g < BEATS; g++) begin : g_beat
        assign w_beat[g] = r_state[g*BW +: BW];
    end

    // Return-valid delay line matching the lane bank pipeline depth
    if (SBOX_LAT == 0) begin : g_nodly
        assign w_ret_vld = sb_vld;
    end else begin : g_dly
        logic [SBOX_LAT-1:0] r_vld_dly;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld_dly <= '0;
            end else begin
                r_vld_dly[0] <= sb_vld;
                for (int i = 1; i < SBOX_LAT; i++) begin
                    r_vld_dly[i] <= r_vld_dly[i-1];
                end
            end
        end
        assign w_ret_vld = r_vld_dly[SBOX_LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE: if (in_valid) w_fsm_nxt = S_RUN;
            S_RUN:  if (w_ret_live && (r_ret == CW'(BEATS - 1))) w_fsm_nxt = S_DONE;
            S_DONE: if (out_ready) w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue <= '0;
            r_ret   <= '0;
        end else if (w_accept) begin
            r_issue <= '0;
            r_ret   <= '0;
        end else begin
            if (w_issue_live) r_issue <= r_issue + CW'(1);
            if (w_ret_live)   r_ret   <= r_ret + CW'(1);
        end
    end

    // Capture on accept, otherwise overwrite the returning beat in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (w_accept) begin
            r_state <= in_state;
        end else if (w_ret_live) begin
            for (int b = 0; b < BEATS; b++) begin
                if (r_ret[IW-1:0] == IW'(b)) begin
                    r_state[b*BW +: BW] <= sb_y;
                end
            end
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        sb_vld    = 1'b0;
        sb_x      = '0;
        out_state = r_state;
        case (r_fsm)
            S_IDLE: in_ready = 1'b1;
            S_RUN: begin
                busy = 1'b1;
                if (w_issue_live) begin
                    sb_vld = 1'b1;
                    sb_x   = w_beat[r_issue[IW-1:0]];
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

endmodule
